// File: rtl/key_evt_pkg.sv
// Shared types and constants for the key event scheduler.
//   EVT_* : 2-bit event type codes carried on evt_type
//   key_evt_t : one FIFO entry {key, typ}. The key field is sized for the
//               largest supported key count (16). Users slice it down to KEY_W.
package key_evt_pkg;
  localparam int KEY_MAX_W = 4;

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  typedef struct packed {
    logic [KEY_MAX_W-1:0] key;
    logic [1:0]           typ;
  } key_evt_t;
endpackage

// File: rtl/key_event_scheduler_if.sv
// Event stream handshake between the scheduler and its consumer.
//   evt_valid : head event present
//   evt_ready : consumer accepts the head event
//   evt_key   : key index of the head event
//   evt_type  : EVT_* code of the head event
// Modports: master = scheduler (producer), slave = game/VGA logic (consumer).
interface key_event_scheduler_if #(
  parameter int KEY_W = 2
);
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_key;
  logic [1:0]       evt_type;

  modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);
endinterface

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and entry (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   head       : entry at the read pointer, valid while !empty
//   full/empty : status
//   level      : number of stored entries
// DEPTH must be a power of 2 so the pointers wrap on their own.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  key_evt_t      din,
  input  logic          pop,
  output key_evt_t      head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  key_evt_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot this same cycle, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q];
  assign level   = level_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/key_event_scheduler.sv
// Merges per-key press/release pulses (and optional auto-repeat) into one
// ordered event stream.
//   clk, reset    : clock, synchronous active-high reset
//   button_state  : debounced level per key (1 = held)
//   pressed       : one-cycle press pulse per key
//   released      : one-cycle release pulse per key
//   evt           : event handshake (master side)
//   fifo_level    : stored event count
//   overflow      : sticky, an event was dropped; overflow_clr clears it
// Optional: define KEY_SCHED_AUTO_REPEAT_EN to add the shared repeat engine
// that produces repeat (11) events for the most recently pressed held key.
//
// Request slot s = key*3 + (type-1). ptr_q holds the slot where the next
// round-robin search starts, i.e. last granted slot + 1.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int          NUM_KEYS     = 4,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [23:0] REPEAT_DELAY = 24'd12_500_000,
  parameter logic [23:0] REPEAT_RATE  = 24'd2_500_000,
  localparam int KEY_W = ($clog2(NUM_KEYS) > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int LW    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_KEYS-1:0]  button_state,
  input  logic [NUM_KEYS-1:0]  pressed,
  input  logic [NUM_KEYS-1:0]  released,
  key_event_scheduler_if.master evt,
  output logic [LW-1:0]        fifo_level,
  output logic                 overflow,
  input  logic                 overflow_clr
);
  localparam int NS = 3 * NUM_KEYS;
  localparam int PW = $clog2(NS);

  logic [NS-1:0]       pend_q, pend_d, req, gnt_oh, drop;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                ovf_q, ovf_d;
  logic [NUM_KEYS-1:0] rep_set;
  logic                gnt_vld, push_ok, pop, full, empty;
  key_evt_t            push_evt, head;
  int                  s;

  assign pop     = !empty && evt.evt_ready;
  assign push_ok = !full || pop;

  // Round-robin: first set slot at or after ptr_q, wrapping.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_oh   = '0;
    push_evt = '0;
    ptr_d    = ptr_q;
    s        = 0;
    for (int i = 0; i < NS; i++) begin
      s = (int'(ptr_q) + i) % NS;
      if (push_ok && !gnt_vld && pend_q[s]) begin
        gnt_vld      = 1'b1;
        gnt_oh[s]    = 1'b1;
        push_evt.key = KEY_MAX_W'(s / 3);
        push_evt.typ = (s % 3 == 0) ? EVT_PRESS : (s % 3 == 1) ? EVT_RELEASE : EVT_REPEAT;
        ptr_d        = (s == NS - 1) ? '0 : PW'(s + 1);
      end
    end
  end

  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      req[3*k]   = pressed[k];
      req[3*k+1] = released[k];
      req[3*k+2] = rep_set[k];
    end
  end

  // A granted slot frees up this cycle, so a new pulse on it is kept.
  assign drop   = req & pend_q & ~gnt_oh;
  assign pend_d = (pend_q & ~gnt_oh) | req;

  always_comb begin
    ovf_d = ovf_q;
    if (overflow_clr) ovf_d = 1'b0;
    if (|drop)        ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      ptr_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef KEY_SCHED_AUTO_REPEAT_EN
  logic [KEY_W-1:0] rkey_q, rkey_d;
  logic [23:0]      rcnt_q, rcnt_d;
  logic             ract_q, ract_d;

  // A press always retargets; on simultaneous presses the highest key wins.
  always_comb begin
    rkey_d  = rkey_q;
    rcnt_d  = rcnt_q;
    ract_d  = ract_q;
    rep_set = '0;
    if (|pressed) begin
      for (int k = 0; k < NUM_KEYS; k++)
        if (pressed[k]) rkey_d = KEY_W'(k);
      rcnt_d = REPEAT_DELAY - 24'd1;
      ract_d = 1'b1;
    end else if (ract_q) begin
      if (released[rkey_q] || !button_state[rkey_q]) begin
        ract_d = 1'b0;
      end else if (rcnt_q == '0) begin
        rep_set[rkey_q] = 1'b1;
        rcnt_d          = REPEAT_RATE - 24'd1;
      end else begin
        rcnt_d = rcnt_q - 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rkey_q <= '0;
      rcnt_q <= '0;
      ract_q <= 1'b0;
    end else begin
      rkey_q <= rkey_d;
      rcnt_q <= rcnt_d;
      ract_q <= ract_d;
    end
  end
`else
  assign rep_set = '0;
  logic unused_rep;
  assign unused_rep = ^{button_state, REPEAT_DELAY, REPEAT_RATE};
`endif

  key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt_vld),
    .din   (push_evt),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  logic unused_head;
  assign unused_head = ^head.key;

  assign evt.evt_valid = !empty;
  assign evt.evt_key   = empty ? '0 : head.key[KEY_W-1:0];
  assign evt.evt_type  = empty ? EVT_NONE : head.typ;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;
  localparam int NK = 4;
  localparam int FD = 4;
  localparam int RD = 10;
  localparam int RR = 4;
  localparam int NS = 3 * NK;
`ifdef KEY_SCHED_AUTO_REPEAT_EN
  localparam int EXP_REP = 6;
`else
  localparam int EXP_REP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] bs = '0, pressed = '0, released = '0;
  logic          ready = 1'b0, clr = 1'b0;
  logic [2:0]    fifo_level;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  key_event_scheduler_if #(.KEY_W(2)) evt_if ();
  assign evt_if.evt_ready = ready;

  key_event_scheduler #(
    .NUM_KEYS(NK), .FIFO_DEPTH(FD),
    .REPEAT_DELAY(24'(RD)), .REPEAT_RATE(24'(RR))
  ) dut (
    .clk(clk), .reset(reset), .button_state(bs), .pressed(pressed),
    .released(released), .evt(evt_if), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(clr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { int key; int typ; } ev_t;
  ev_t mq[$];
  bit  m_pend[NS];
  int  m_start = 0;
  bit  m_ovf = 0;
  bit  m_ract = 0;
  int  m_rkey = 0;
  int  m_tpress = 0;
  int  cyc = 0;

  task automatic model_edge();
    int  gnt;
    bit  push_ok, pop_now, drop, r;
    bit  rep[NK];
    cyc++;
    if (reset) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      mq.delete();
      m_start = 0; m_ovf = 0; m_ract = 0;
      return;
    end
    foreach (rep[i]) rep[i] = 0;
`ifdef KEY_SCHED_AUTO_REPEAT_EN
    if (pressed != 0) begin
      for (int k = 0; k < NK; k++) if (pressed[k]) m_rkey = k;
      m_ract = 1; m_tpress = cyc;
    end else if (m_ract) begin
      if (released[m_rkey] || !bs[m_rkey]) m_ract = 0;
      else if ((cyc - m_tpress) >= RD && ((cyc - m_tpress - RD) % RR) == 0) rep[m_rkey] = 1;
    end
`endif
    pop_now = (mq.size() > 0) && ready;
    push_ok = (mq.size() < FD) || pop_now;
    gnt = -1;
    if (push_ok)
      for (int i = 0; i < NS; i++) begin
        int sl;
        sl = (m_start + i) % NS;
        if (m_pend[sl]) begin gnt = sl; break; end
      end
    if (pop_now) void'(mq.pop_front());
    if (gnt >= 0) begin
      mq.push_back('{gnt / 3, gnt % 3 + 1});
      m_pend[gnt] = 0;
      m_start = (gnt + 1) % NS;
    end
    drop = 0;
    for (int k = 0; k < NK; k++)
      for (int t = 0; t < 3; t++) begin
        r = (t == 0) ? pressed[k] : (t == 1) ? released[k] : rep[k];
        if (r) begin
          if (m_pend[3*k+t]) drop = 1;
          else m_pend[3*k+t] = 1;
        end
      end
    if (clr)  m_ovf = 0;
    if (drop) m_ovf = 1;
  endtask

  function automatic int exp_key();  return mq.size() ? mq[0].key : 0; endfunction
  function automatic int exp_type(); return mq.size() ? mq[0].typ : 0; endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pressed = NK'($urandom); released = NK'($urandom); bs = NK'($urandom);
      ready = 1'(($urandom)); clr = 1'b0;
      step();
      checks += 4;
      if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_if.evt_valid); end
      if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
      if (evt_if.evt_type !== 2'b00) begin errors++; $display("FAIL reset_type got %b want 00", evt_if.evt_type); end
    end
    reset = 1'b0; pressed = '0; released = '0; bs = '0; ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    int exp_k[3] = '{0, 1, 3};
    ready = 1'b1;
    pressed = 4'b1011;
    step();
    pressed = '0;
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL simul_edge_t got valid %b want 0", evt_if.evt_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL simul_valid%0d got %b want 1", i, evt_if.evt_valid); end
      if (evt_if.evt_key !== 2'(exp_k[i])) begin errors++; $display("FAIL simul_key%0d got %0d want %0d", i, evt_if.evt_key, exp_k[i]); end
      if (evt_if.evt_type !== 2'b01) begin errors++; $display("FAIL simul_type%0d got %b want 01", i, evt_if.evt_type); end
    end
    step();
    checks += 2;
    if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL simul_drained got %b want 0", evt_if.evt_valid); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    int keys[5] = '{0, 1, 2, 3, 0};
    int got[$];
    ready = 1'b0;
    foreach (keys[i]) begin
      pressed = NK'(1 << keys[i]);
      step();
    end
    pressed = '0;
    step();
    checks += 3;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d want 4", fifo_level); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf got %b want 0", overflow); end
    if (evt_if.evt_key !== 2'd0) begin errors++; $display("FAIL bp_head got %0d want 0", evt_if.evt_key); end
    // sixth pulse on key 0 hits its still-pending flag
    pressed = 4'b0001;
    step();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b want 1", overflow); end
    // clear and drop together: set wins
    clr = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_drop got %b want 1", overflow); end
    pressed = '0;
    step();
    clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got %b want 0", overflow); end
    // full + pop + pending flag: push and pop together
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (evt_if.evt_valid) got.push_back(int'(evt_if.evt_key));
      step();
      if (i == 0) begin
        checks++;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_pop_level got %0d want 4", fifo_level); end
      end
    end
    checks += 2;
    if (got.size() != 5) begin errors++; $display("FAIL drain_count got %0d want 5", got.size()); end
    else foreach (keys[i])
      if (got[i] != keys[i]) begin errors++; $display("FAIL drain_order idx %0d got %0d want %0d", i, got[i], keys[i]); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL drain_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_repeat();
    int t_press = -1, n_rep = 0, n_rel = 0, n_press = 0, t_rel = -1;
    int rep_t[$];
    ready = 1'b1;
    pressed = 4'b0100; bs = 4'b0100;
    step();
    pressed = '0;
    for (int i = 0; i < 46; i++) begin
      if (i == 30) begin released = 4'b0100; bs = '0; end
      step();
      released = '0;
      checks++;
      if (evt_if.evt_type !== 2'(exp_type())) begin errors++; $display("FAIL rep_model cyc %0d got %b want %0d", i, evt_if.evt_type, exp_type()); end
      if (evt_if.evt_valid) begin
        case (evt_if.evt_type)
          2'b01: begin n_press++; t_press = cyc; end
          2'b11: begin n_rep++; rep_t.push_back(cyc); end
          2'b10: begin n_rel++; t_rel = cyc; end
          default: ;
        endcase
      end
    end
    checks += 4;
    if (n_press != 1) begin errors++; $display("FAIL rep_press got %0d want 1", n_press); end
    if (n_rep != EXP_REP) begin errors++; $display("FAIL rep_count got %0d want %0d", n_rep, EXP_REP); end
    if (n_rel != 1) begin errors++; $display("FAIL rep_release got %0d want 1", n_rel); end
    if (t_rel != t_press + 31) begin errors++; $display("FAIL rep_rel_time got %0d want %0d", t_rel - t_press, 31); end
    foreach (rep_t[i]) begin
      checks++;
      if (rep_t[i] != t_press + RD + RR * i) begin errors++; $display("FAIL rep_time%0d got +%0d want +%0d", i, rep_t[i] - t_press, RD + RR * i); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NK; k++) begin
        pressed[k]  = !bs[k] && ($urandom_range(0, 7) == 0);
        released[k] =  bs[k] && ($urandom_range(0, 11) == 0);
      end
      bs = (bs | pressed) & ~released;
      ready = ($urandom_range(0, 9) < 6);
      clr   = ($urandom_range(0, 15) == 0);
      step();
      checks += 5;
      if (evt_if.evt_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d got %b want %0d", c, evt_if.evt_valid, mq.size() != 0); end
      if (evt_if.evt_key !== 2'(exp_key())) begin errors++; $display("FAIL rnd_key c%0d got %0d want %0d", c, evt_if.evt_key, exp_key()); end
      if (evt_if.evt_type !== 2'(exp_type())) begin errors++; $display("FAIL rnd_type c%0d got %b want %0d", c, evt_if.evt_type, exp_type()); end
      if (fifo_level !== 3'(mq.size())) begin errors++; $display("FAIL rnd_level c%0d got %0d want %0d", c, fifo_level, mq.size()); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d got %b want %b", c, overflow, m_ovf); end
    end
    pressed = '0; released = '0; clr = 1'b0;
    // leave the FIFO loaded so the following reset has state to clear
    ready = 1'b0;
    pressed = 4'b1111;
    step();
    pressed = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_backpressure();
    test_repeat();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
